cceip_axi_mem_responder: RTL and testbench

AXI4 slave memory responder that terminates the cceip kernel's `m00_axi` master port. It serves AW/W/B and AR/R bursts from an internal word-addressed RAM. It is the simulation and loopback target for kernel read/write traffic, such as the input fetch, the output-size write and the output-data write. Read and write channels run independently, and each channel has its own FSM.

---
 rtl/cceip_axi_mem_responder_if.sv | 42 ++++
 rtl/cceip_axi_mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_cceip_axi_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cceip_axi_mem_responder_if.sv
// AXI4 subset (AW/W/B/AR/R, INCR bursts, OKAY-only responses) between the cceip
// kernel m00_axi master and the loopback memory responder.
interface cceip_axi_mem_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/cceip_axi_mem_responder.sv
// AXI4 slave memory responder terminating the cceip m00_axi port from a word RAM.
// Optional ready/valid throttling via an LFSR: define CCEIP_AXI_MEM_RESP_BACKPRESSURE_EN.
//
// state  | meaning
// W_IDLE | waiting for AW (awready)
// W_DATA | accepting W beats into RAM (wready)
// W_RESP | presenting OKAY response (bvalid) until bready
// R_IDLE | waiting for AR (arready)
// R_DATA | presenting read beats (rvalid, rlast on final beat)
module cceip_axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  cceip_axi_mem_responder_if.slave s_axi,
  output logic                     err_wlast
);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  logic             run;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic [7:0]       w_len, w_cnt, r_len, r_cnt;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic awready_i, wready_i, bvalid_i, arready_i, rvalid_i;
  logic aw_gate, w_gate, ar_gate, r_raise;
  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_last_beat, r_last_beat;
  logic [IDX_W-1:0] aw_index, ar_index;
  logic unused_addr_bits;

  assign aw_index = s_axi.awaddr[OFF_W +: IDX_W];
  assign ar_index = s_axi.araddr[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

  // Readies stay low through reset and rise on the first edge after release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) run <= 1'b0;
    else           run <= 1'b1;
  end

`ifdef CCEIP_AXI_MEM_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        r_shown;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) lfsr <= 16'hACE1;
    else           lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Once rvalid is shown it must persist until the handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_shown <= 1'b0;
    else           r_shown <= rvalid_i & ~s_axi.rready;
  end

  assign aw_gate = lfsr[0];
  assign w_gate  = lfsr[1];
  assign ar_gate = lfsr[2];
  assign r_raise = r_shown | lfsr[3];
`else
  assign aw_gate = 1'b1;
  assign w_gate  = 1'b1;
  assign ar_gate = 1'b1;
  assign r_raise = 1'b1;
`endif

  assign aw_hs = s_axi.awvalid & awready_i;
  assign w_hs  = s_axi.wvalid  & wready_i;
  assign ar_hs = s_axi.arvalid & arready_i;
  assign r_hs  = s_axi.rready  & rvalid_i;

  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);

  // ---------------- write channel ----------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) w_state <= W_IDLE;
    else           w_state <= w_next;
  end

  always_comb begin
    w_next    = w_state;
    awready_i = 1'b0;
    wready_i  = 1'b0;
    bvalid_i  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_i = run & aw_gate;
        if (s_axi.awvalid & awready_i) w_next = W_DATA;
      end
      W_DATA: begin
        wready_i = w_gate;
        if (s_axi.wvalid & wready_i & (w_last_beat | s_axi.wlast)) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid_i = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      err_wlast <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_idx <= aw_index;
        w_len <= s_axi.awlen;
        w_cnt <= '0;
      end
      if (w_hs) begin
        w_idx <= w_idx + IDX_W'(1);
        w_cnt <= w_cnt + 8'd1;
        if (w_last_beat != s_axi.wlast) err_wlast <= 1'b1;
      end
    end
  end

  // RAM is intentionally not reset; contents survive ap_rst_n.
  always_ff @(posedge ap_clk) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= R_IDLE;
    else           r_state <= r_next;
  end

  always_comb begin
    r_next    = r_state;
    arready_i = 1'b0;
    rvalid_i  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_i = run & ar_gate;
        if (s_axi.arvalid & arready_i) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid_i = r_raise;
        if (s_axi.rready & rvalid_i & r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Non-blocking RAM read gives read-first behaviour on a same-word write.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
    end else if (ar_hs) begin
      r_len   <= s_axi.arlen;
      r_cnt   <= '0;
      rdata_q <= mem[ar_index];
      r_idx   <= ar_index + IDX_W'(1);
    end else if (r_hs && !r_last_beat) begin
      rdata_q <= mem[r_idx];
      r_idx   <= r_idx + IDX_W'(1);
      r_cnt   <= r_cnt + 8'd1;
    end
  end

  assign s_axi.awready = awready_i;
  assign s_axi.wready  = wready_i;
  assign s_axi.bvalid  = bvalid_i;
  assign s_axi.arready = arready_i;
  assign s_axi.rvalid  = rvalid_i;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rlast   = (r_state == R_DATA) & r_last_beat;
endmodule

// File: tb/tb_cceip_axi_mem_responder.sv
// Self-checking bench for cceip_axi_mem_responder: vector table, directed corner
// sequences and randomized bursts against a word-array memory model.
module tb_cceip_axi_mem_responder;
  localparam int AW = 64, DW = 64, DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_wlast;
  always #5 clk = ~clk;

  cceip_axi_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) s_axi ();

  cceip_axi_mem_responder #(
    .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .C_MEM_DEPTH(DEPTH)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .s_axi(s_axi), .err_wlast(err_wlast)
  );

  int total = 0, passed = 0;
  logic [63:0] model_mem [DEPTH];
  bit          model_err = 0;
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];
  logic [63:0] rbuf [256];

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  function automatic int widx(input logic [63:0] addr);
    return int'((addr >> 3) % DEPTH);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [7:0] strb);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  // Sends nbeats of wbuf/sbuf; wlast is raised on beat last_at (-1: never).
  task automatic axi_write(input logic [63:0] addr, input int len, input int nbeats,
                           input int last_at, input bit gaps);
    int t;
    int base = widx(addr);
    s_axi.awvalid = 1'b1; s_axi.awaddr = addr; s_axi.awlen = 8'(len);
    t = 0;
    while (s_axi.awready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) timeout("aw_handshake");
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
`ifndef CCEIP_AXI_MEM_RESP_BACKPRESSURE_EN
    chk("wready_after_aw", s_axi.wready, 1'b1);
`endif
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_axi.wvalid = 1'b0; @(posedge clk); #1;
      end
      s_axi.wvalid = 1'b1; s_axi.wdata = wbuf[i]; s_axi.wstrb = sbuf[i];
      s_axi.wlast = (i == last_at);
      t = 0;
      while (s_axi.wready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) timeout("w_handshake");
      @(posedge clk); #1;
      model_mem[(base + i) % DEPTH] = merge(model_mem[(base + i) % DEPTH], wbuf[i], sbuf[i]);
      if ((i == last_at) != (i == len)) model_err = 1;
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    chk("bvalid_after_last_w", s_axi.bvalid, 1'b1);
    chk("err_wlast", err_wlast, model_err);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      chk("bvalid_hold", s_axi.bvalid, 1'b1);
    end
    s_axi.bready = 1'b1;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
    chk("bvalid_clear", s_axi.bvalid, 1'b0);
`ifndef CCEIP_AXI_MEM_RESP_BACKPRESSURE_EN
    chk("awready_after_b", s_axi.awready, 1'b1);
`endif
  endtask

  task automatic axi_read(input logic [63:0] addr, input int len, input bit stalls);
    int t, beat;
    int base = widx(addr);
    logic [63:0] held = '0;
    bit was_stalled = 0;
    s_axi.arvalid = 1'b1; s_axi.araddr = addr; s_axi.arlen = 8'(len);
    t = 0;
    while (s_axi.arready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) timeout("ar_handshake");
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
`ifndef CCEIP_AXI_MEM_RESP_BACKPRESSURE_EN
    chk("rvalid_after_ar", s_axi.rvalid, 1'b1);
`endif
    beat = 0; t = 0;
    while (beat <= len && t < 2000) begin
      s_axi.rready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (was_stalled) chk("rdata_stable", s_axi.rdata, held);
      was_stalled = 0;
      if (s_axi.rvalid === 1'b1) begin
        if (s_axi.rready) begin
          chk("rdata", s_axi.rdata, model_mem[(base + beat) % DEPTH]);
          chk("rlast", s_axi.rlast, beat == len);
          rbuf[beat] = s_axi.rdata;
          beat++;
        end else begin
          held = s_axi.rdata; was_stalled = 1;
        end
      end
      @(posedge clk); #1; t++;
    end
    if (beat <= len) timeout("r_beats");
    s_axi.rready = 1'b0;
    chk("rvalid_clear", s_axi.rvalid, 1'b0);
`ifndef CCEIP_AXI_MEM_RESP_BACKPRESSURE_EN
    chk("arready_after_rlast", s_axi.arready, 1'b1);
`endif
  endtask

  initial begin
    vecs[0] = '{64'h10,  64'h0000_0000_0000_1234, 8'hFF, 64'h0000_0000_0000_1234};
    vecs[1] = '{64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{64'h200, 64'h0,                   8'h0F, 64'hFFFF_FFFF_0000_0000};
    vecs[3] = '{64'h205, 64'h1122_3344_5566_7788, 8'h30, 64'hFFFF_3344_0000_0000};
    vecs[4] = '{64'h2008, 64'hDEAD,               8'hFF, 64'hDEAD};
    vecs[5] = '{64'h8,   64'hFFFF,                8'h00, 64'hDEAD};

    s_axi.awvalid = 0; s_axi.awaddr = 0; s_axi.awlen = 0;
    s_axi.wvalid = 0; s_axi.wdata = 0; s_axi.wstrb = 0; s_axi.wlast = 0;
    s_axi.bready = 0; s_axi.arvalid = 0; s_axi.araddr = 0; s_axi.arlen = 0;
    s_axi.rready = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", s_axi.awready, 0);
    chk("rst_wready", s_axi.wready, 0);
    chk("rst_bvalid", s_axi.bvalid, 0);
    chk("rst_arready", s_axi.arready, 0);
    chk("rst_rvalid", s_axi.rvalid, 0);
    chk("rst_rdata", s_axi.rdata, 0);
    chk("rst_rlast", s_axi.rlast, 0);
    chk("rst_err_wlast", err_wlast, 0);
    rst_n = 1'b1;
    #1;
    chk("awready_before_edge", s_axi.awready, 0);
    @(posedge clk); #1;
    chk("awready_after_release", s_axi.awready, 1);
    chk("arready_after_release", s_axi.arready, 1);

    // Preload the whole RAM with four maximum-length bursts
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(k * 256 + i);
        sbuf[i] = 8'hFF;
      end
      axi_write(64'(k * 2048), 255, 256, 255, 0);
    end
    axi_read(64'h7F8, 0, 0);
    chk("preload_word_255", rbuf[0], 64'hC0DE_0000_0000_00FF);

    // Single-beat vector table
    for (int i = 0; i < 6; i++) begin
      wbuf[0] = vecs[i].data; sbuf[0] = vecs[i].strb;
      axi_write(vecs[i].addr, 0, 1, 0, 0);
      axi_read(vecs[i].addr, 0, 0);
      chk($sformatf("vec%0d_rdata", i), rbuf[0], vecs[i].exp);
    end

    // 16-beat loopback with a 3-cycle rready stall on beat 5
    for (int i = 0; i < 16; i++) begin wbuf[i] = 64'hA0 + 64'(i); sbuf[i] = 8'hFF; end
    axi_write(64'h100, 15, 16, 15, 0);
    s_axi.arvalid = 1'b1; s_axi.araddr = 64'h100; s_axi.arlen = 8'd15;
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    for (int beat = 0; beat < 16; beat++) begin
      if (beat == 5) begin
        s_axi.rready = 1'b0;
        repeat (3) begin
          chk("stall_rvalid", s_axi.rvalid, 1);
          chk("stall_rdata", s_axi.rdata, 64'hA5);
          chk("stall_rlast", s_axi.rlast, 0);
          @(posedge clk); #1;
        end
      end
      s_axi.rready = 1'b1;
      chk("burst_rvalid", s_axi.rvalid, 1);
      chk("burst_rdata", s_axi.rdata, 64'hA0 + 64'(beat));
      chk("burst_rlast", s_axi.rlast, beat == 15);
      @(posedge clk); #1;
    end
    s_axi.rready = 1'b0;
    chk("burst_arready_back", s_axi.arready, 1);

    // Index wrap: 1022, 1023, 0, 1
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'h5000 + 64'(i); sbuf[i] = 8'hFF; end
    axi_write(64'h1FF0, 3, 4, 3, 0);
    axi_read(64'h1FF0, 3, 0);
    for (int i = 0; i < 4; i++) chk("wrap_read", rbuf[i], 64'h5000 + 64'(i));
    axi_read(64'h0, 1, 0);
    chk("wrap_word0", rbuf[0], 64'h5002);
    chk("wrap_word1", rbuf[1], 64'h5003);

    // Early wlast truncates the burst
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'h0; sbuf[i] = 8'hFF; end
    axi_write(64'h400, 3, 4, 3, 0);
    chk("err_clean_burst", err_wlast, 0);
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hE0 + 64'(i);
    axi_write(64'h400, 3, 2, 1, 0);
    chk("err_early_wlast", err_wlast, 1);
    axi_read(64'h400, 3, 0);
    chk("trunc_w0", rbuf[0], 64'hE0);
    chk("trunc_w1", rbuf[1], 64'hE1);
    chk("trunc_w2", rbuf[2], 64'h0);
    chk("trunc_w3", rbuf[3], 64'h0);

    // Reset during beat 2 of a 4-beat read
    s_axi.arvalid = 1'b1; s_axi.araddr = 64'h100; s_axi.arlen = 8'd3;
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrd_beat2", s_axi.rdata, 64'hA2);
    rst_n = 1'b0;
    #1;
    chk("midrd_rvalid", s_axi.rvalid, 0);
    chk("midrd_rlast", s_axi.rlast, 0);
    chk("midrd_arready", s_axi.arready, 0);
    chk("midrd_err_cleared", err_wlast, 0);
    model_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; s_axi.rready = 1'b0;
    #1;
    chk("midrd_arready_pre", s_axi.arready, 0);
    @(posedge clk); #1;
    chk("midrd_arready_post", s_axi.arready, 1);
    axi_read(64'h100, 15, 0);
    chk("midrd_intact", rbuf[2], 64'hA2);

    // Missing wlast on final beat
    wbuf[0] = 64'h77; wbuf[1] = 64'h78; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    axi_write(64'h800, 1, 2, -1, 0);
    chk("err_missing_wlast", err_wlast, 1);
    axi_read(64'h800, 1, 0);
    chk("nolast_w0", rbuf[0], 64'h77);
    chk("nolast_w1", rbuf[1], 64'h78);

    // Randomized bursts with W gaps and R stalls
    for (int n = 0; n < 12; n++) begin
      int len = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) begin
        wbuf[i] = {$urandom, $urandom};
        sbuf[i] = 8'($urandom);
      end
      axi_write(64'($urandom_range(0, 16'h3FFF)), len, len + 1, len, 1);
      axi_read(64'($urandom_range(0, 16'h3FFF)), $urandom_range(0, 15), 1);
    end

    // Concurrent write (low half) and read (high half)
    for (int n = 0; n < 4; n++) begin
      int wl = $urandom_range(0, 15);
      int rl = $urandom_range(0, 15);
      logic [63:0] wa = 64'($urandom_range(0, 400)) << 3;
      logic [63:0] ra = 64'($urandom_range(512, 1000)) << 3;
      for (int i = 0; i <= wl; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
      fork
        axi_write(wa, wl, wl + 1, wl, 1);
        axi_read(ra, rl, 1);
      join
      axi_read(wa, wl, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
